// File: rtl/prog_loader_pkg.sv
// Shared definitions for the instruction-memory loader:
// FSM state encoding, frame field order and checksum step.
package prog_loader_pkg;

    // FSM state encoding (4-bit)
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_LEN_HI  = 4'd1;
    localparam logic [3:0] ST_LEN_LO  = 4'd2;
    localparam logic [3:0] ST_DATA_HI = 4'd3;
    localparam logic [3:0] ST_DATA_LO = 4'd4;
    localparam logic [3:0] ST_WRITE   = 4'd5;
    localparam logic [3:0] ST_CHK     = 4'd6;
    localparam logic [3:0] ST_DONE    = 4'd7;
    localparam logic [3:0] ST_ERR     = 4'd8;

    // Frame field order on the byte stream
    typedef enum logic [2:0] {
        FLD_LEN_HI,
        FLD_LEN_LO,
        FLD_DATA_HI,
        FLD_DATA_LO,
        FLD_CHK
    } frame_field_e;

    // Checksum: XOR of every DATA byte, length bytes excluded
    function automatic logic [7:0] chk_step(
        input logic [7:0] acc,
        input logic [7:0] b
    );
        return acc ^ b;
    endfunction

    // States that accept a stream byte
    function automatic logic st_rx(input logic [3:0] st);
        return st inside {ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
                          ST_DATA_LO, ST_CHK};
    endfunction

    // States that count as a load in progress
    function automatic logic st_busy(input logic [3:0] st);
        return !(st inside {ST_IDLE, ST_DONE, ST_ERR});
    endfunction

endpackage

// File: rtl/prog_loader_wordpack.sv
// Byte-pair assembly register and running XOR checksum.
// Ports: clk, rst, clr (clear checksum), hi_en/lo_en (latch din), word, acc.
module prog_loader_wordpack
    import prog_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        hi_en,
    input  logic        lo_en,
    input  logic [7:0]  din,
    output logic [15:0] word,
    output logic [7:0]  acc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            word <= '0;
            acc  <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (hi_en || lo_en) begin
                acc <= chk_step(acc, din);
            end
            if (hi_en) word[15:8] <= din;
            if (lo_en) word[7:0]  <= din;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Framed byte stream -> instruction memory writer; holds the core in reset
// until a load completes with a good checksum.
// Ports: clk, rst, i_start, i_byte/i_byte_valid/o_byte_ready (stream),
//        o_wr/o_waddr/o_wdata (rom write port), o_cpu_rst, o_busy,
//        o_done, o_err, o_count.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int   ROM_AWIDTH  = 8,
    parameter logic CPU_RST_POL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic [7:0]            i_byte,
    input  logic                  i_byte_valid,
    output logic                  o_byte_ready,
    output logic                  o_wr,
    output logic [ROM_AWIDTH-1:0] o_waddr,
    output logic [15:0]           o_wdata,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err,
    output logic [ROM_AWIDTH:0]   o_count
);

    localparam logic [16:0] MAX_N = 17'd1 << ROM_AWIDTH;

    logic [3:0]            state, state_nx;
    logic [7:0]            len_hi;
    logic [15:0]           len;
    logic [ROM_AWIDTH-1:0] addr;
    logic [ROM_AWIDTH:0]   count;
    logic [ROM_AWIDTH:0]   cnt_nx;
    logic [15:0]           n_rx;
    logic [7:0]            acc;
    logic                  xfer;
    logic                  can_start;
    logic                  last;

    assign xfer      = i_byte_valid && o_byte_ready;
    assign can_start = i_start &&
                       (state inside {ST_IDLE, ST_DONE, ST_ERR});
    assign n_rx      = {len_hi, i_byte};
    assign cnt_nx    = count + 1'b1;
    assign last      = 17'(cnt_nx) == {1'b0, len};

    always_comb begin
        state_nx = state;
        if (can_start) begin
            state_nx = ST_LEN_HI;
        end else begin
            unique case (state)
                ST_LEN_HI:  if (xfer) state_nx = ST_LEN_LO;
                ST_LEN_LO: begin
                    if (xfer) begin
                        if (n_rx == 16'd0)
                            state_nx = ST_CHK;
                        else if ({1'b0, n_rx} > MAX_N)
                            state_nx = ST_ERR;
                        else
                            state_nx = ST_DATA_HI;
                    end
                end
                ST_DATA_HI: if (xfer) state_nx = ST_DATA_LO;
                ST_DATA_LO: if (xfer) state_nx = ST_WRITE;
                ST_WRITE:   state_nx = last ? ST_CHK : ST_DATA_HI;
                ST_CHK: begin
                    if (xfer)
                        state_nx = (i_byte == acc) ? ST_DONE : ST_ERR;
                end
                ST_IDLE, ST_DONE, ST_ERR: state_nx = state;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up
    // with the state register itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_hi       <= '0;
            len          <= '0;
            addr         <= '0;
            count        <= '0;
            o_wr         <= 1'b0;
            o_byte_ready <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            o_cpu_rst    <= CPU_RST_POL;
        end else begin
            state        <= state_nx;
            o_wr         <= state_nx == ST_WRITE;
            o_byte_ready <= st_rx(state_nx);
            o_busy       <= st_busy(state_nx);
            o_done       <= state_nx == ST_DONE;
            o_err        <= state_nx == ST_ERR;
            o_cpu_rst    <= (state_nx == ST_DONE) ? ~CPU_RST_POL
                                                  : CPU_RST_POL;
            if (can_start) begin
                addr  <= '0;
                count <= '0;
            end
            if (state == ST_LEN_HI && xfer) len_hi <= i_byte;
            if (state == ST_LEN_LO && xfer) len    <= n_rx;
            if (state == ST_WRITE) begin
                addr  <= addr + 1'b1;
                count <= cnt_nx;
            end
        end
    end

    prog_loader_wordpack u_pack (
        .clk   (clk),
        .rst   (rst),
        .clr   (can_start),
        .hi_en (state == ST_DATA_HI && xfer),
        .lo_en (state == ST_DATA_LO && xfer),
        .din   (i_byte),
        .word  (o_wdata),
        .acc   (acc)
    );

    assign o_waddr = addr;
    assign o_count = count;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected rom writes are queued as
// words are sent and checked as o_wr pulses appear.
module tb_prog_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [7:0]    i_byte;
    logic          i_byte_valid;
    logic          o_byte_ready;
    logic          o_wr;
    logic [AW-1:0] o_waddr;
    logic [15:0]   o_wdata;
    logic          o_cpu_rst;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [AW:0]   o_count;

    always #5 clk = ~clk;

    prog_loader #(.ROM_AWIDTH(AW), .CPU_RST_POL(1'b0)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_wr         (o_wr),
        .o_waddr      (o_waddr),
        .o_wdata      (o_wdata),
        .o_cpu_rst    (o_cpu_rst),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_count      (o_count)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [23:0] exp_q[$];
    logic [23:0] exp_e;
    logic [15:0] wq[$];
    int          wr_cnt = 0;
    logic [7:0]  last_addr;
    bit          gaps = 0;

    always @(negedge clk) begin
        if (o_wr) begin
            wr_cnt++;
            last_addr = o_waddr;
            if (exp_q.size() == 0) begin
                check("wr_extra", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", o_waddr, exp_e[23:16]);
                check("wr_data", o_wdata, exp_e[15:0]);
            end
        end
    end

    // All tasks start and end at posedge+1.
    task automatic send(input logic [7:0] b);
        int t = 0;
        if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
                i_byte_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        i_byte = b;
        i_byte_valid = 1'b1;
        @(negedge clk);
        while (!o_byte_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check("rdy_timeout", 32'd0, 32'd1);
            i_byte_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        i_byte_valid = 1'b0;
        i_byte = $urandom_range(0, 255);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic begin_load();
        wr_cnt = 0;
        pulse_start();
        check("st_done", o_done, 0);
        check("st_err", o_err, 0);
        check("st_busy", o_busy, 1);
        check("st_held", o_cpu_rst, 0);
        check("st_count", o_count, 0);
    endtask

    task automatic word(input int a, input logic [15:0] w);
        send(w[15:8]);
        exp_q.push_back({8'(a), w});
        send(w[7:0]);
    endtask

    function automatic logic [7:0] wq_chk(input int n);
        logic [7:0] c = 8'h00;
        for (int i = 0; i < n; i++) c = c ^ wq[i][15:8] ^ wq[i][7:0];
        return c;
    endfunction

    task automatic frame(input int n, input bit bad);
        logic [15:0] nn = 16'(n);
        begin_load();
        send(nn[15:8]);
        send(nn[7:0]);
        for (int i = 0; i < n; i++) word(i, wq[i]);
        check("pre_chk_held", o_cpu_rst, 0);
        send(bad ? wq_chk(n) ^ 8'h5A : wq_chk(n));
    endtask

    task automatic expect_end(input string tag, input bit good, input int n);
        check({tag, "_done"}, o_done, 32'(good));
        check({tag, "_err"}, o_err, 32'(!good));
        check({tag, "_cpurst"}, o_cpu_rst, 32'(good));
        check({tag, "_rdy"}, o_byte_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_count"}, o_count, 32'(n));
        @(posedge clk); #1;
        check({tag, "_wrs"}, wr_cnt, 32'(n));
        check({tag, "_pending"}, exp_q.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_wr"}, o_wr, 0);
        check({tag, "_waddr"}, o_waddr, 0);
        check({tag, "_wdata"}, o_wdata, 0);
        check({tag, "_rdy"}, o_byte_ready, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_err"}, o_err, 0);
        check({tag, "_count"}, o_count, 0);
        check({tag, "_cpurst"}, o_cpu_rst, 0);
    endtask

    task automatic set_base();
        wq = {16'h1234, 16'hABCD, 16'h00FF};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_byte = 8'h00;
        i_byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("rst");
        rst = 1'b0;
        @(posedge clk); #1;

        // Three words, no gaps
        set_base();
        frame(3, 0);
        expect_end("load3", 1, 3);

        // Reload from DONE with a different frame
        wq = {16'hCAFE, 16'h0001};
        frame(2, 0);
        expect_end("reload", 1, 2);

        // Bad checksum
        set_base();
        frame(3, 1);
        expect_end("badchk", 0, 3);

        // Oversized length: error right after LEN_LO
        begin_load();
        send(8'h01);
        send(8'h01);
        check("len_err", o_err, 1);
        check("len_busy", o_busy, 0);
        check("len_rdy", o_byte_ready, 0);
        check("len_held", o_cpu_rst, 0);
        expect_end("lenmax", 0, 0);

        // Zero-length frame
        wq = {};
        frame(0, 0);
        expect_end("len0", 1, 0);

        // Full capacity
        wq = {};
        for (int i = 0; i < 256; i++) wq.push_back(16'($urandom));
        frame(256, 0);
        expect_end("full", 1, 256);
        check("full_last", last_addr, 8'hFF);

        // Random valid gaps
        gaps = 1;
        set_base();
        frame(3, 0);
        expect_end("gaps", 1, 3);
        gaps = 0;

        // i_start while in DATA_LO is ignored
        set_base();
        begin_load();
        send(8'h00);
        send(8'h03);
        send(8'h12);
        pulse_start();
        check("ign_busy", o_busy, 1);
        check("ign_rdy", o_byte_ready, 1);
        exp_q.push_back({8'h00, 16'h1234});
        send(8'h34);
        word(1, 16'hABCD);
        word(2, 16'h00FF);
        send(wq_chk(3));
        expect_end("ignstart", 1, 3);

        // Reset after DATA_HI of word 2
        begin_load();
        send(8'h00);
        send(8'h03);
        word(0, 16'h1234);
        send(8'hAB);
        rst = 1'b1;
        @(posedge clk); #1;
        reset_checks("midrst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_wrs", wr_cnt, 1);
        frame(3, 0);
        expect_end("afterrst", 1, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
